// File: rtl/mem_pipe_ctrl_if.sv
// Request/response bus between a master and the pipelined memory controller.
interface mem_pipe_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  clr;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, clr,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, clr,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/mem_pipe_ctrl.sv
// Register-array memory with byte-enabled writes, pipelined reads and a
// self-clearing init sweep that replaces a whole-array reset.
module mem_pipe_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_pipe_ctrl_if.slave  bus
);
    localparam int unsigned BE_W = DATA_W / 8;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_d;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;

    logic              pv [RD_LAT];
    logic [DATA_W-1:0] pd [RD_LAT];
    logic              pe [RD_LAT];

    // Widened compare so a power-of-two DEPTH never wraps to zero.
    assign in_range      = ({1'b0, bus.req_addr} < (ADDR_W+1)'(DEPTH));
    assign bus.req_ready = (state == ST_IDLE) && !bus.clr;
    assign bus.busy      = (state == ST_INIT);
    assign accept        = bus.req_valid && bus.req_ready;
    assign rd_acc        = accept && !bus.req_we;
    assign wr_acc        = accept && bus.req_we;
    assign rd_word       = in_range ? mem[bus.req_addr] : '0;

    // Next-state logic: sweep every index once, then serve requests until clr.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            ST_INIT: begin
                cnt_d = cnt + ADDR_W'(1);
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (bus.clr) begin
                    state_d = ST_INIT;
                end
            end
        endcase
    end

    // State and sweep counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Storage: sweep zeroing in INIT, byte-masked writes otherwise.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[cnt] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (bus.req_be[i]) begin
                    mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // First read stage samples the array at the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv[0] <= 1'b0;
            pd[0] <= '0;
            pe[0] <= 1'b0;
        end else begin
            pv[0] <= rd_acc;
            pe[0] <= rd_acc && !in_range;
            if (rd_acc) begin
                pd[0] <= rd_word;
            end
        end
    end

    // Further stages; data only moves with a valid so the output holds.
    for (genvar g = 1; g < int'(RD_LAT); g++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pv[g] <= 1'b0;
                pd[g] <= '0;
                pe[g] <= 1'b0;
            end else begin
                pv[g] <= pv[g-1];
                pe[g] <= pe[g-1];
                if (pv[g-1]) begin
                    pd[g] <= pd[g-1];
                end
            end
        end
    end

    assign bus.rsp_valid = pv[RD_LAT-1];
    assign bus.rsp_data  = pd[RD_LAT-1];
    assign bus.rsp_err   = pe[RD_LAT-1];
endmodule

// File: tb/tb_mem_pipe_ctrl.sv
// Scoreboard bench: three DEPTH=16 instances (RD_LAT 2/1/4) share stimulus,
// a DEPTH=12 instance covers out-of-range addressing and reset behaviour.
module tb_mem_pipe_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_d;
    logic v, we, clr_s;
    logic [3:0] addr, be;
    logic [31:0] wd;
    logic dv, dwe, dclr;
    logic [3:0] daddr, dbe;
    logic [31:0] dwd;

    mem_pipe_ctrl_if #(.DATA_W(32), .ADDR_W(4)) ifa ();
    mem_pipe_ctrl_if #(.DATA_W(32), .ADDR_W(4)) ifb ();
    mem_pipe_ctrl_if #(.DATA_W(32), .ADDR_W(4)) ifc ();
    mem_pipe_ctrl_if #(.DATA_W(32), .ADDR_W(4)) ifd ();

    assign ifa.req_valid = v;  assign ifb.req_valid = v;  assign ifc.req_valid = v;
    assign ifa.req_we    = we; assign ifb.req_we    = we; assign ifc.req_we    = we;
    assign ifa.req_addr  = addr; assign ifb.req_addr = addr; assign ifc.req_addr = addr;
    assign ifa.req_wdata = wd; assign ifb.req_wdata = wd; assign ifc.req_wdata = wd;
    assign ifa.req_be    = be; assign ifb.req_be    = be; assign ifc.req_be    = be;
    assign ifa.clr       = clr_s; assign ifb.clr    = clr_s; assign ifc.clr    = clr_s;
    assign ifd.req_valid = dv;
    assign ifd.req_we    = dwe;
    assign ifd.req_addr  = daddr;
    assign ifd.req_wdata = dwd;
    assign ifd.req_be    = dbe;
    assign ifd.clr       = dclr;

    mem_pipe_ctrl #(.DATA_W(32), .DEPTH(16), .RD_LAT(2)) dut_a (.clk(clk), .rst(rst),   .bus(ifa));
    mem_pipe_ctrl #(.DATA_W(32), .DEPTH(16), .RD_LAT(1)) dut_b (.clk(clk), .rst(rst),   .bus(ifb));
    mem_pipe_ctrl #(.DATA_W(32), .DEPTH(16), .RD_LAT(4)) dut_c (.clk(clk), .rst(rst),   .bus(ifc));
    mem_pipe_ctrl #(.DATA_W(32), .DEPTH(12), .RD_LAT(2)) dut_d (.clk(clk), .rst(rst_d), .bus(ifd));

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } exp_t;

    exp_t q [4][$];
    int   cyc = 0;
    int   pass = 0;
    int   total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        case (k)
            1:       return 1;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic rdy_of(input int id);
        return (id == 3) ? ifd.req_ready : ifa.req_ready;
    endfunction

    function automatic logic busy_of(input int id);
        return (id == 3) ? ifd.busy : ifa.busy;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        else pass++;
    endtask

    // Drive one request at a negedge; reads push their expected response.
    task automatic op(input int id, input bit w, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic [31:0] ed, input bit ee, input bit push);
        if (id == 3) begin
            dv = 1'b1; dwe = w; daddr = a; dwd = d; dbe = b;
        end else begin
            v = 1'b1; we = w; addr = a; wd = d; be = b;
        end
        #1;
        chk($sformatf("accept_dut%0d", id), 32'(rdy_of(id)), 32'd1);
        if (!w && push) begin
            if (id == 3) q[3].push_back('{ed, ee, cyc + 2});
            else for (int k = 0; k < 3; k++) q[k].push_back('{ed, ee, cyc + lat_of(k)});
        end
        @(negedge clk);
        v = 1'b0; dv = 1'b0;
    endtask

    // Count cycles of busy; req_ready must stay low and rise once busy drops.
    task automatic sweep(input int id, input int n);
        int k;
        bit bad;
        k = 0; bad = 1'b0;
        while (busy_of(id) && k < 200) begin
            if (rdy_of(id)) bad = 1'b1;
            @(negedge clk);
            k++;
        end
        chk($sformatf("sweep_len_dut%0d", id), 32'(k), 32'(n));
        chk($sformatf("ready_after_sweep_dut%0d", id), 32'(rdy_of(id)), 32'd1);
        chk($sformatf("ready_low_in_sweep_dut%0d", id), 32'(bad), 32'd0);
    endtask

    task automatic mon(input int id, input logic valid, input logic [31:0] data, input logic err);
        exp_t e;
        if (q[id].size() != 0 && q[id][0].due < cyc) begin
            total++;
            $display("FAIL rsp_missing_dut%0d: no response by cycle %0d, required data %h", id, cyc, q[id][0].d);
            void'(q[id].pop_front());
        end
        if (valid) begin
            if (q[id].size() == 0) begin
                total++;
                $display("FAIL rsp_unexpected_dut%0d: got data %h, required no response (cycle %0d)", id, data, cyc);
            end else begin
                e = q[id].pop_front();
                chk($sformatf("rsp_data_dut%0d", id), data, e.d);
                chk($sformatf("rsp_err_dut%0d", id), 32'(err), 32'(e.e));
                chk($sformatf("rsp_cycle_dut%0d", id), 32'(cyc), 32'(e.due));
            end
        end else if (err) begin
            chk($sformatf("rsp_err_idle_dut%0d", id), 32'(err), 32'd0);
        end
    endtask

    always @(negedge clk) mon(0, ifa.rsp_valid, ifa.rsp_data, ifa.rsp_err);
    always @(negedge clk) mon(1, ifb.rsp_valid, ifb.rsp_data, ifb.rsp_err);
    always @(negedge clk) mon(2, ifc.rsp_valid, ifc.rsp_data, ifc.rsp_err);
    always @(negedge clk) mon(3, ifd.rsp_valid, ifd.rsp_data, ifd.rsp_err);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; rst_d = 1'b1;
        v = 1'b0; we = 1'b0; addr = '0; wd = '0; be = '0; clr_s = 1'b0;
        dv = 1'b0; dwe = 1'b0; daddr = '0; dwd = '0; dbe = '0; dclr = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        chk("rst_rsp_data",  ifa.rsp_data, 32'd0);
        chk("rst_rsp_err",   32'(ifa.rsp_err), 32'd0);
        chk("rst_busy",      32'(ifa.busy), 32'd1);
        chk("rst_ready",     32'(ifa.req_ready), 32'd0);
        chk("rst_busy_c",    32'(ifc.busy), 32'd1);

        rst = 1'b0;
        sweep(0, 16);

        // Whole array reads back as zero after init
        for (int i = 0; i < 16; i++) op(0, 1'b0, 4'(i), 32'd0, 4'h0, 32'd0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);

        // Byte enables, including an all-zero mask
        op(0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, 1'b0);
        op(0, 1'b1, 4'd3, 32'h11223344, 4'h5, 32'd0, 1'b0, 1'b0);
        op(0, 1'b0, 4'd3, 32'd0, 4'h0, 32'hDE22BE44, 1'b0, 1'b1);
        op(0, 1'b1, 4'd3, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0, 1'b0);
        op(0, 1'b0, 4'd3, 32'd0, 4'h0, 32'hDE22BE44, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        chk("hold_data_a", ifa.rsp_data, 32'hDE22BE44);
        chk("hold_data_c", ifc.rsp_data, 32'hDE22BE44);

        // Throughput and ordering
        for (int i = 0; i < 16; i++) op(0, 1'b1, 4'(i), 32'(i) * 32'h01010101, 4'hF, 32'd0, 1'b0, 1'b0);
        for (int i = 15; i >= 0; i--) op(0, 1'b0, 4'(i), 32'd0, 4'h0, 32'(i) * 32'h01010101, 1'b0, 1'b1);
        repeat (6) @(negedge clk);

        // Read immediately after write
        op(0, 1'b1, 4'd7, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0, 1'b0);
        op(0, 1'b0, 4'd7, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0, 1'b1);
        repeat (6) @(negedge clk);

        // Clear with an in-flight read
        op(0, 1'b1, 4'd2, 32'h12345678, 4'hF, 32'd0, 1'b0, 1'b0);
        op(0, 1'b0, 4'd2, 32'd0, 4'h0, 32'h12345678, 1'b0, 1'b1);
        clr_s = 1'b1;
        n = 0;
        #1;
        while (!ifa.req_ready && n < 200) begin
            n++;
            @(negedge clk);
            clr_s = 1'b0;
            #1;
        end
        chk("clr_ready_low_cycles", 32'(n), 32'd17);
        @(negedge clk);
        op(0, 1'b0, 4'd2, 32'd0, 4'h0, 32'd0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);

        // DEPTH=12 instance: out-of-range accesses
        rst_d = 1'b0;
        sweep(3, 12);
        op(3, 1'b1, 4'd5,  32'h00000055, 4'hF, 32'd0, 1'b0, 1'b0);
        op(3, 1'b1, 4'd13, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b0, 1'b0);
        op(3, 1'b0, 4'd13, 32'd0, 4'h0, 32'd0, 1'b1, 1'b1);
        op(3, 1'b0, 4'd5,  32'd0, 4'h0, 32'h00000055, 1'b0, 1'b1);
        op(3, 1'b0, 4'd1,  32'd0, 4'h0, 32'd0, 1'b0, 1'b1);
        op(3, 1'b0, 4'd11, 32'd0, 4'h0, 32'd0, 1'b0, 1'b1);
        op(3, 1'b0, 4'd12, 32'd0, 4'h0, 32'd0, 1'b1, 1'b1);
        repeat (6) @(negedge clk);

        // Reset mid-sweep restarts the full sweep
        dclr = 1'b1;
        @(negedge clk);
        dclr = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_sweep_busy_d", 32'(ifd.busy), 32'd1);
        rst_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0;
        sweep(3, 12);

        // Reset drops an in-flight read, then the sweep has cleared the data
        op(3, 1'b1, 4'd5, 32'h00000066, 4'hF, 32'd0, 1'b0, 1'b0);
        op(3, 1'b0, 4'd5, 32'd0, 4'h0, 32'd0, 1'b0, 1'b0);
        rst_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0;
        sweep(3, 12);
        op(3, 1'b0, 4'd5, 32'd0, 4'h0, 32'd0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);

        for (int k = 0; k < 4; k++) chk($sformatf("queue_empty_dut%0d", k), 32'(q[k].size()), 32'd0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/mem_pipe_ctrl.md
# mem_pipe_ctrl

Parametrised successor to the team's single-port register-array memory. Configurable data width, depth and read latency; per-byte write enables; a valid/ready request handshake; a pipelined read-response path; and a self-clearing init sweep in place of a combinational whole-array reset. Sits between a class-based testbench driver (or bus master) and local storage. Accepts one request per cycle at full throughput.

## Interface
- DATA_W, 32, data width in bits; multiple of 8
- DEPTH, 16, number of words; ≥ 2
- ADDR_W, $clog2(DEPTH), address width
- RD_LAT, 1, read latency in cycles; legal 1..4
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- req_be  input  DATA_W/8  byte enables; bit i covers bits [8i+7:8i]
- clr  input  1  start a clear sweep (level-sampled)
- rsp_valid  output  1  read response valid; 1-cycle pulse per read
- rsp_data  output  DATA_W  read data
- rsp_err  output  1  read address was out of range; qualified by rsp_valid
- busy  output  1  init/clear sweep in progress

## Operation
- States: INIT (sweep) and IDLE. A sweep counter `cnt` (ADDR_W bits) runs only in INIT.
- INIT behaviour:
  - Each edge writes 0 to mem[cnt], then increments cnt.
  - After the edge that writes index DEPTH-1: go to IDLE and reset cnt to 0.
  - busy = 1 and req_ready = 0 throughout INIT.
- IDLE behaviour: req_ready = !clr; busy = 0.
- clr = 1 in IDLE: go to INIT on the next edge; no request is accepted that cycle. clr during INIT is ignored; the sweep does not restart.
- Accept: a request is accepted when req_valid && req_ready at a rising edge. Requests are processed strictly in acceptance order.
- Write:
  - Bytes with req_be[i] = 1 are updated at the accept edge; other bytes are unchanged.
  - be = 0 is a legal no-op.
  - A write produces no response.
- Read:
  - Data is sampled from the array at the accept edge. It reflects all writes accepted on earlier edges; a same-edge write is impossible with a single port.
  - The sample passes through RD_LAT-1 further register stages.
  - rsp_valid pulses exactly once per accepted read.
- Out of range (req_addr ≥ DEPTH, only possible when DEPTH is not a power of two):
  - Write: discarded; no array change.
  - Read: rsp_data = 0 and rsp_err = 1.
- No response back-pressure. The consumer must accept every rsp_valid pulse.
- In-flight reads at clr still complete with their pre-clear data.
- When rsp_valid = 0: rsp_data holds its last value and rsp_err = 0.

## Timing
- rst asserted (asynchronous):
  - State = INIT, cnt = 0.
  - All pipeline valid bits cleared; rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - req_ready = 0, busy = 1.
  - Array contents are not reset directly.
- After rst deasserts, the sweep runs DEPTH edges. req_ready first reads 1 after the DEPTH-th edge.
- rst mid-sweep or mid-read: the sweep restarts from 0 and all in-flight responses are dropped.
- Read latency: a read accepted at edge N gives rsp_valid = 1 in the cycle after edge N+RD_LAT-1, i.e. exactly RD_LAT cycles after the accept cycle.
- Back-to-back reads produce back-to-back rsp_valid pulses in the same order.
- Write at edge N, then a read of the same address at edge N+1: the read returns the new data.
- A clr sweep from IDLE takes DEPTH+1 cycles of req_ready = 0: one cycle for the clr request and DEPTH for the sweep.

## Test plan
All scenarios use DATA_W = 32, DEPTH = 16, RD_LAT = 2 unless stated.
- **Reset/init:** pulse rst, release → busy = 1 and req_ready = 0 for 16 cycles, then req_ready = 1. Reading all 16 addresses returns 0 with rsp_err = 0.
- **Byte enables:**
  - write 0xDEADBEEF to addr 3 with be = 0xF;
  - then write 0x11223344 to addr 3 with be = 0x5;
  - read addr 3 → rsp_data = 0xDE22BE44, arriving 2 cycles after accept.
- **Throughput/order:** write addr i = i·0x01010101 for i = 0..15; issue 16 back-to-back reads in order 15..0 → 16 consecutive rsp_valid cycles with data 0x0F0F0F0F … 0x00000000. Repeat with RD_LAT = 1 and RD_LAT = 4; latency must track the setting.
- **Read-after-write:** write 0xA5A5A5A5 to addr 7 and read addr 7 on the next cycle → 0xA5A5A5A5.
- **Clear with in-flight read:**
  - addr 2 holds 0x12345678;
  - read addr 2, assert clr the next cycle;
  - → response 0x12345678 still arrives, busy = 1 for 16 cycles, then a read of addr 2 returns 0.
- **Out of range (DEPTH = 12):**
  - write 0xFFFFFFFF to addr 13 → no array change;
  - read addr 13 → rsp_data = 0, rsp_err = 1;
  - assert rst mid-sweep → cnt restarts and the full 12-cycle sweep repeats.
